// File: rtl/chrono_lap_controller.sv
// chrono_lap_controller
//   Sequencing controller for the 4-digit BCD stopwatch counter chain.
//   Turns the start/stop and lap/reset button pulses into the counter run
//   enable, a counter clear pulse, the lap freeze flag and the value shown
//   on the LCD. Up to N_LAPS lap times are stored and replayed in RECALL.
//
// Ports
//   clk_in       system clock
//   reset_n      asynchronous active-low reset
//   pulse_ss     start/stop pulse, 1 cycle wide
//   pulse_lr     lap/reset pulse, 1 cycle wide
//   live_bcd     counter chain value {deca,unit,deci,centi}
//   run_enable   counter chain counts while high
//   counter_clr  1-cycle clear pulse for the counter chain
//   lap_flag     display shows a stored or frozen value
//   display_bcd  value sent to the LCD driver (1 cycle latency)
//   state        FSM state code (LEDs)
//   lap_count    number of stored laps
//   lap_index    lap shown in RECALL
//   overflow     sticky: a lap was captured while memory was full
module chrono_lap_controller #(
    parameter int N_LAPS = 8,
    parameter int IDX_W  = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             pulse_ss,
    input  logic             pulse_lr,
    input  logic [15:0]      live_bcd,
    output logic             run_enable,
    output logic             counter_clr,
    output logic             lap_flag,
    output logic [15:0]      display_bcd,
    output logic [2:0]       state,
    output logic [IDX_W:0]   lap_count,
    output logic [IDX_W-1:0] lap_index,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STOP     = 3'd2,
        LAP_RUN  = 3'd3,
        LAP_STOP = 3'd4,
        RECALL   = 3'd5
    } state_t;

    localparam logic [IDX_W:0] LAPS_MAX = (IDX_W + 1)'(N_LAPS);
    localparam logic [IDX_W:0] ONE      = (IDX_W + 1)'(1);

    state_t             state_q, state_d;
    logic               ss_q, lr_q;
    logic               ss_acc, lr_acc;
    logic               capture, clear_laps, clr_d, last_lap, mem_we;
    logic               run_d, lapf_d, ovf_d;
    logic [IDX_W:0]     count_d;
    logic [IDX_W-1:0]   index_d;
    logic [15:0]        frozen, frozen_d, display_d;
    logic [15:0]        mem [N_LAPS];

    // Pulses are registered once, so a pulse seen at edge k acts at edge k+1.
    // Start/stop has priority; a coincident lap/reset pulse is dropped.
    assign ss_acc   = ss_q;
    assign lr_acc   = lr_q & ~ss_q;
    assign last_lap = ({1'b0, lap_index} == (lap_count - ONE));
    assign state    = state_q;

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        clear_laps = 1'b0;
        clr_d      = 1'b0;
        index_d    = lap_index;
        case (state_q)
            IDLE: begin
                if (ss_acc) state_d = RUN;
            end
            RUN: begin
                if (ss_acc) begin
                    state_d = STOP;
                end else if (lr_acc) begin
                    capture = 1'b1;
                    state_d = LAP_RUN;
                end
            end
            LAP_RUN: begin
                if (ss_acc)      state_d = LAP_STOP;
                else if (lr_acc) capture = 1'b1;
            end
            LAP_STOP: begin
                if (ss_acc)      state_d = LAP_RUN;
                else if (lr_acc) state_d = STOP;
            end
            STOP: begin
                if (ss_acc) begin
                    state_d = RUN;
                end else if (lr_acc) begin
                    clr_d = 1'b1;
                    if (lap_count != '0) begin
                        state_d = RECALL;
                        index_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RECALL: begin
                if (ss_acc || (lr_acc && last_lap)) begin
                    clear_laps = 1'b1;
                    index_d    = '0;
                    state_d    = IDLE;
                end else if (lr_acc) begin
                    index_d = lap_index + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; outputs are registered from the next state so
    // they line up with the state register.
    always_comb begin
        mem_we   = capture && (lap_count < LAPS_MAX);
        count_d  = lap_count;
        ovf_d    = overflow;
        frozen_d = frozen;
        if (capture) begin
            frozen_d = live_bcd;
            if (mem_we) count_d = lap_count + ONE;
            else        ovf_d   = 1'b1;
        end
        if (clear_laps) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
        run_d  = (state_d == RUN) || (state_d == LAP_RUN);
        lapf_d = (state_d == LAP_RUN) || (state_d == LAP_STOP) || (state_d == RECALL);
        case (state_d)
            LAP_RUN, LAP_STOP: display_d = frozen_d;
            RECALL:            display_d = mem[index_d];
            default:           display_d = live_bcd;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ss_q        <= 1'b0;
            lr_q        <= 1'b0;
            run_enable  <= 1'b0;
            counter_clr <= 1'b0;
            lap_flag    <= 1'b0;
            display_bcd <= '0;
            lap_count   <= '0;
            lap_index   <= '0;
            overflow    <= 1'b0;
            frozen      <= '0;
        end else begin
            state_q     <= state_d;
            ss_q        <= pulse_ss;
            lr_q        <= pulse_lr;
            run_enable  <= run_d;
            counter_clr <= clr_d;
            lap_flag    <= lapf_d;
            display_bcd <= display_d;
            lap_count   <= count_d;
            lap_index   <= index_d;
            overflow    <= ovf_d;
            frozen      <= frozen_d;
        end
    end

    // Lap memory has no reset; entries are only read after being written.
    always_ff @(posedge clk_in) begin
        if (mem_we) mem[lap_count[IDX_W-1:0]] <= live_bcd;
    end

endmodule

// File: tb/tb_chrono_lap_controller.sv
module tb_chrono_lap_controller;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        pulse_ss, pulse_lr;
    logic [15:0] live_bcd;
    logic        run_enable, counter_clr, lap_flag, overflow;
    logic [15:0] display_bcd;
    logic [2:0]  state;
    logic [3:0]  lap_count;
    logic [2:0]  lap_index;

    chrono_lap_controller #(.N_LAPS(8), .IDX_W(3)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .pulse_ss    (pulse_ss),
        .pulse_lr    (pulse_lr),
        .live_bcd    (live_bcd),
        .run_enable  (run_enable),
        .counter_clr (counter_clr),
        .lap_flag    (lap_flag),
        .display_bcd (display_bcd),
        .state       (state),
        .lap_count   (lap_count),
        .lap_index   (lap_index),
        .overflow    (overflow)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard: {state, run, clr, lapf, disp, cnt, idx, ovf} = 30 bits
    typedef struct {
        int          cyc;
        logic [29:0] v;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic exp_at(input string nm, input int d, input logic [2:0] st,
                          input logic run, input logic clr, input logic lapf,
                          input logic [15:0] disp, input logic [3:0] cnt,
                          input logic [2:0] idx, input logic ovf);
        exp_t e;
        e.cyc = cyc + d;
        e.v   = {st, run, clr, lapf, disp, cnt, idx, ovf};
        q.push_back(e);
        nq.push_back(nm);
    endtask

    always @(negedge clk_in) begin
        exp_t        e;
        string       nm;
        logic [29:0] a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            a  = {state, run_enable, counter_clr, lap_flag, display_bcd,
                  lap_count, lap_index, overflow};
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL %s: got st=%0d run=%b clr=%b lap=%b disp=%h cnt=%0d idx=%0d ovf=%b, want st=%0d run=%b clr=%b lap=%b disp=%h cnt=%0d idx=%0d ovf=%b",
                         nm, a[29:27], a[26], a[25], a[24], a[23:8], a[7:4], a[3:1], a[0],
                         e.v[29:27], e.v[26], e.v[25], e.v[24], e.v[23:8], e.v[7:4], e.v[3:1], e.v[0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input logic s, input logic l);
        pulse_ss = s;
        pulse_lr = l;
        @(posedge clk_in);
        #1;
        pulse_ss = 1'b0;
        pulse_lr = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        reset_n  = 1'b0;
        pulse_ss = 1'b0;
        pulse_lr = 1'b0;
        live_bcd = 16'h0000;
        step(2);
        exp_at("reset", 0, 3'd0, 0, 0, 0, 16'h0000, 4'd0, 3'd0, 0);
        reset_n = 1'b1;
        exp_at("idle", 1, 3'd0, 0, 0, 0, 16'h0000, 4'd0, 3'd0, 0);
        step(2);

        // start, two laps
        pulse(1, 0);
        exp_at("start", 1, 3'd1, 1, 0, 0, 16'h0000, 4'd0, 3'd0, 0);
        step(2);
        live_bcd = 16'h0123;
        step(1);
        pulse(0, 1);
        exp_at("lap1", 1, 3'd3, 1, 0, 1, 16'h0123, 4'd1, 3'd0, 0);
        step(2);
        live_bcd = 16'h0456;
        pulse(0, 1);
        exp_at("lap2", 1, 3'd3, 1, 0, 1, 16'h0456, 4'd2, 3'd0, 0);
        step(2);

        // LAP_RUN -> LAP_STOP -> STOP, display goes live
        live_bcd = 16'h0789;
        pulse(1, 0);
        exp_at("lap_stop", 1, 3'd4, 0, 0, 1, 16'h0456, 4'd2, 3'd0, 0);
        step(2);
        pulse(0, 1);
        exp_at("stop_live", 1, 3'd2, 0, 0, 0, 16'h0789, 4'd2, 3'd0, 0);
        step(1);
        live_bcd = 16'h1111;
        exp_at("stop_hold", 0, 3'd2, 0, 0, 0, 16'h0789, 4'd2, 3'd0, 0);
        exp_at("stop_track", 1, 3'd2, 0, 0, 0, 16'h1111, 4'd2, 3'd0, 0);
        step(2);

        // recall two laps, exit on last lr
        pulse(0, 1);
        exp_at("recall0", 1, 3'd5, 0, 1, 1, 16'h0123, 4'd2, 3'd0, 0);
        exp_at("recall0_clr_off", 2, 3'd5, 0, 0, 1, 16'h0123, 4'd2, 3'd0, 0);
        step(2);
        pulse(0, 1);
        exp_at("recall1", 1, 3'd5, 0, 0, 1, 16'h0456, 4'd2, 3'd1, 0);
        step(2);
        pulse(0, 1);
        exp_at("recall_exit", 1, 3'd0, 0, 0, 0, 16'h1111, 4'd0, 3'd0, 0);
        step(2);

        // simultaneous pulses in RUN, then STOP with no laps -> IDLE
        pulse(1, 0);
        exp_at("run2", 1, 3'd1, 1, 0, 0, 16'h1111, 4'd0, 3'd0, 0);
        step(2);
        pulse(1, 1);
        exp_at("ss_wins", 1, 3'd2, 0, 0, 0, 16'h1111, 4'd0, 3'd0, 0);
        exp_at("no_capture", 2, 3'd2, 0, 0, 0, 16'h1111, 4'd0, 3'd0, 0);
        step(2);
        pulse(0, 1);
        exp_at("clr_to_idle", 1, 3'd0, 0, 1, 0, 16'h1111, 4'd0, 3'd0, 0);
        exp_at("clr_one_cycle", 2, 3'd0, 0, 0, 0, 16'h1111, 4'd0, 3'd0, 0);
        step(2);

        // 9 captures into 8-deep memory
        pulse(1, 0);
        exp_at("run3", 1, 3'd1, 1, 0, 0, 16'h1111, 4'd0, 3'd0, 0);
        step(2);
        for (int i = 1; i <= 9; i++) begin
            v = 16'h0100 + 16'(i);
            live_bcd = v;
            pulse(0, 1);
            exp_at($sformatf("cap%0d", i), 1, 3'd3, 1, 0, 1, v,
                   (i > 8) ? 4'd8 : 4'(i), 3'd0, (i == 9));
            step(2);
        end
        pulse(1, 0);
        exp_at("lapstop_full", 1, 3'd4, 0, 0, 1, 16'h0109, 4'd8, 3'd0, 1);
        step(2);
        live_bcd = 16'h2468;
        pulse(0, 1);
        exp_at("stop_full", 1, 3'd2, 0, 0, 0, 16'h2468, 4'd8, 3'd0, 1);
        step(2);
        pulse(0, 1);
        exp_at("recall_full0", 1, 3'd5, 0, 1, 1, 16'h0101, 4'd8, 3'd0, 1);
        step(2);
        for (int k = 1; k <= 7; k++) begin
            v = 16'h0101 + 16'(k);
            pulse(0, 1);
            exp_at($sformatf("recall_full%0d", k), 1, 3'd5, 0, 0, 1, v, 4'd8, 3'(k), 1);
            step(2);
        end
        pulse(1, 0);
        exp_at("recall_ss_exit", 1, 3'd0, 0, 0, 0, 16'h2468, 4'd0, 3'd0, 0);
        step(2);

        // reset mid-RUN, asserted between edges
        pulse(1, 0);
        exp_at("run4", 1, 3'd1, 1, 0, 0, 16'h2468, 4'd0, 3'd0, 0);
        step(2);
        pulse(0, 1);
        exp_at("lap_pre_reset", 1, 3'd3, 1, 0, 1, 16'h2468, 4'd1, 3'd0, 0);
        step(2);
        live_bcd = 16'h3333;
        exp_at("async_reset", 0, 3'd0, 0, 0, 0, 16'h0000, 4'd0, 3'd0, 0);
        #2 reset_n = 1'b0;
        step(3);
        exp_at("reset_held", 0, 3'd0, 0, 0, 0, 16'h0000, 4'd0, 3'd0, 0);
        reset_n = 1'b1;
        exp_at("post_reset", 1, 3'd0, 0, 0, 0, 16'h3333, 4'd0, 3'd0, 0);
        step(3);

        for (int w = 0; w < 10 && q.size() > 0; w++) step(1);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
